ir_fetch_seq: RTL and testbench

//   Byte-serial instruction fetch sequencer feeding the instruction register. On a fetch request it

---
 rtl/srp16_pkg.sv | 14 +
 rtl/fetch_wait_ctr.sv | 31 +++
 rtl/ir_fetch_seq.sv | 149 ++++++++++++++
 tb/tb_ir_fetch_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srp16_pkg.sv
// Shared definitions for the byte-serial instruction fetch path.
package srp16_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned INSTR_W    = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRdLo = 2'd1,
        StRdHi = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_wait_ctr.sv
// Wait-state counter for unanswered memory reads. o_tc flags that one more
// unanswered cycle brings the count to MAX_WAIT, so the FSM can time out on that edge.
module fetch_wait_ctr #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count unanswered read cycles; clear has priority over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST_CNT);

endmodule

// File: rtl/ir_fetch_seq.sv
// Byte-serial instruction fetch: reads lo byte at pc and hi byte at pc+1, then
// holds the assembled word for the IR with a valid/ack handshake.
module ir_fetch_seq
    import srp16_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_pc_in,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_rd,
    input  logic               i_mem_rdy,
    input  logic [7:0]         i_mem_din,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_ack,
    output logic [ADDR_W-1:0]  o_pc_next,
    output logic               o_busy,
    output logic               o_err
);

    fetch_state_e        r_state, w_state_d;
    logic [ADDR_W-1:0]   r_pc, w_pc_d;
    logic [7:0]          r_lo, w_lo_d;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
    logic                r_mem_rd, w_mem_rd_d;
    logic [INSTR_W-1:0]  r_instr, w_instr_d;
    logic                r_valid, w_valid_d;
    logic [ADDR_W-1:0]   r_pc_next, w_pc_next_d;
    logic                r_err, w_err_d;

    logic w_reading;
    logic w_ctr_clr;
    logic w_ctr_inc;
    logic w_ctr_tc;

    assign w_reading = (r_state == StRdLo) || (r_state == StRdHi);
    assign w_ctr_inc = w_reading && !i_mem_rdy;
    // Any state change (incl. flush and timeout) or a served byte restarts the wait count.
    assign w_ctr_clr = i_flush || (w_state_d != r_state) || (w_reading && i_mem_rdy);

    fetch_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_ctr_clr),
        .i_inc   (w_ctr_inc),
        .o_tc    (w_ctr_tc)
    );

    // Next-state and datapath update; flush overrides every other input.
    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_lo_d       = r_lo;
        w_mem_addr_d = r_mem_addr;
        w_mem_rd_d   = r_mem_rd;
        w_instr_d    = r_instr;
        w_valid_d    = r_valid;
        w_pc_next_d  = r_pc_next;
        w_err_d      = r_err;
        if (i_flush) begin
            w_state_d  = StIdle;
            w_mem_rd_d = 1'b0;
            w_valid_d  = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_pc_d       = i_pc_in;
                        w_pc_next_d  = i_pc_in + ADDR_W'(2);
                        w_err_d      = 1'b0;
                        w_mem_addr_d = i_pc_in;
                        w_mem_rd_d   = 1'b1;
                        w_state_d    = StRdLo;
                    end
                end
                StRdLo: begin
                    if (i_mem_rdy) begin
                        w_lo_d       = i_mem_din;
                        w_mem_addr_d = r_pc + ADDR_W'(1);
                        w_state_d    = StRdHi;
                    end else if (w_ctr_tc) begin
                        w_err_d    = 1'b1;
                        w_mem_rd_d = 1'b0;
                        w_state_d  = StIdle;
                    end
                end
                StRdHi: begin
                    if (i_mem_rdy) begin
                        w_instr_d  = {i_mem_din, r_lo};
                        w_mem_rd_d = 1'b0;
                        w_valid_d  = 1'b1;
                        w_state_d  = StHold;
                    end else if (w_ctr_tc) begin
                        w_err_d    = 1'b1;
                        w_mem_rd_d = 1'b0;
                        w_state_d  = StIdle;
                    end
                end
                StHold: begin
                    if (i_instr_ack) begin
                        w_valid_d = 1'b0;
                        w_state_d = StIdle;
                    end
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_pc       <= '0;
            r_lo       <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_pc_next  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_lo       <= w_lo_d;
            r_mem_addr <= w_mem_addr_d;
            r_mem_rd   <= w_mem_rd_d;
            r_instr    <= w_instr_d;
            r_valid    <= w_valid_d;
            r_pc_next  <= w_pc_next_d;
            r_err      <= w_err_d;
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_rd      = r_mem_rd;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc_next     = r_pc_next;
    assign o_busy        = (r_state != StIdle);
    assign o_err         = r_err;

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Self-checking bench for ir_fetch_seq: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ir_fetch_seq;

    localparam int unsigned MW = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] pc_in = '0;
    logic        mem_rdy = 1'b0;
    logic [7:0]  mem_din = '0;
    logic        ack = 1'b0;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_next;
    logic        busy;
    logic        err;

    ir_fetch_seq #(
        .ADDR_W   (16),
        .MAX_WAIT (MW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_flush       (flush),
        .i_pc_in       (pc_in),
        .o_mem_addr    (mem_addr),
        .o_mem_rd      (mem_rd),
        .i_mem_rdy     (mem_rdy),
        .i_mem_din     (mem_din),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .i_instr_ack   (ack),
        .o_pc_next     (pc_next),
        .o_busy        (busy),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory image and responder policy.
    logic [7:0] mem [0:65535];
    int rdy_mode  = 0;   // 0 always ready, 1 fixed delay, 2 never, 3 random percentage
    int rdy_delay = 0;
    int dly_cnt   = 0;
    int rdy_pct   = 100;

    task automatic tick();
        @(negedge clk);
        mem_din = mem[mem_addr];
        case (rdy_mode)
            0: mem_rdy = 1'b1;
            1: begin
                if (mem_rd) begin
                    if (dly_cnt >= rdy_delay) begin
                        mem_rdy = 1'b1;
                        dly_cnt = 0;
                    end else begin
                        mem_rdy = 1'b0;
                        dly_cnt++;
                    end
                end else begin
                    mem_rdy = 1'b0;
                    dly_cnt = 0;
                end
            end
            2: mem_rdy = 1'b0;
            default: mem_rdy = ($urandom_range(99) < rdy_pct);
        endcase
    endtask

    // Behavioural model: fetch in progress, bytes received so far, word held.
    logic        m_busy, m_hold, m_rd, m_valid, m_err;
    int          m_nb, m_wait;
    logic [15:0] m_pc, m_pcn, m_addr, m_instr;
    logic [7:0]  m_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_hold = 0; m_rd = 0; m_valid = 0; m_err = 0;
            m_nb = 0; m_wait = 0;
            m_pc = '0; m_pcn = '0; m_addr = '0; m_instr = '0; m_lo = '0;
        end else begin
            if (flush) begin
                m_busy = 0; m_hold = 0; m_rd = 0; m_valid = 0; m_wait = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_pc = pc_in; m_pcn = pc_in + 16'd2; m_err = 0;
                    m_addr = pc_in; m_rd = 1; m_busy = 1; m_nb = 0; m_wait = 0;
                end
            end else if (m_hold) begin
                if (ack) begin
                    m_valid = 0; m_busy = 0; m_hold = 0;
                end
            end else if (mem_rdy) begin
                m_wait = 0;
                if (m_nb == 0) begin
                    m_lo = mem_din; m_nb = 1; m_addr = m_pc + 16'd1;
                end else begin
                    m_instr = {mem_din, m_lo}; m_rd = 0; m_valid = 1; m_hold = 1;
                end
            end else begin
                m_wait++;
                if (m_wait == MW) begin
                    m_err = 1; m_rd = 0; m_busy = 0; m_wait = 0;
                end
            end
            #1;
            check("mdl_busy", busy, m_busy);
            check("mdl_mem_rd", mem_rd, m_rd);
            if (m_rd) check("mdl_mem_addr", mem_addr, m_addr);
            check("mdl_instr", instr, m_instr);
            check("mdl_valid", instr_valid, m_valid);
            check("mdl_pc_next", pc_next, m_pcn);
            check("mdl_err", err, m_err);
        end
    end

    int lat;
    int k;
    int pcts [6] = '{100, 70, 40, 15, 5, 60};

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_instr", instr, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_pc_next", pc_next, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back reads at 0x0100
        mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
        start = 1; pc_in = 16'h0100; tick(); start = 0;
        check("t1_addr_lo", mem_addr, 16'h0100);
        check("t1_rd", mem_rd, 1'b1);
        check("t1_pc_next", pc_next, 16'h0102);
        check("t1_valid_c1", instr_valid, 1'b0);
        tick();
        check("t1_addr_hi", mem_addr, 16'h0101);
        check("t1_valid_c2", instr_valid, 1'b0);
        tick();
        check("t1_valid_c3", instr_valid, 1'b1);
        check("t1_instr", instr, 16'h1234);
        check("t1_rd_off", mem_rd, 1'b0);
        ack = 1; tick(); ack = 0;
        check("t1_idle", busy, 1'b0);
        check("t1_valid_off", instr_valid, 1'b0);
        check("t1_instr_kept", instr, 16'h1234);

        // 2: address wrap at 0xFFFF
        mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
        start = 1; pc_in = 16'hFFFF; tick(); start = 0;
        check("t2_pc_next", pc_next, 16'h0001);
        tick();
        check("t2_addr_wrap", mem_addr, 16'h0000);
        tick();
        check("t2_instr", instr, 16'hABCD);
        ack = 1; tick(); ack = 0;

        // 3: four wait cycles per byte, then a long hold
        rdy_mode = 1; rdy_delay = 4; dly_cnt = 0;
        mem[16'h2000] = 8'h78; mem[16'h2001] = 8'h56;
        start = 1; pc_in = 16'h2000; tick(); start = 0;
        lat = 1;
        while (!instr_valid && lat < 40) begin
            check("t3_rd_held", mem_rd, 1'b1);
            tick();
            lat++;
        end
        check("t3_latency", lat, 11);
        check("t3_instr", instr, 16'h5678);
        check("t3_err", err, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            pc_in = 16'h7777;
            tick();
            check("t3_hold_valid", instr_valid, 1'b1);
            check("t3_hold_instr", instr, 16'h5678);
        end
        check("t3_pc_next_kept", pc_next, 16'h2002);
        ack = 1; start = 1; tick(); ack = 0; start = 0;
        check("t3_start_in_ack_ignored", busy, 1'b0);

        // 4: memory never answers
        rdy_mode = 2;
        start = 1; pc_in = 16'h3000; tick(); start = 0;
        k = 1;
        while (!err && k < 40) begin
            tick();
            k++;
        end
        check("t4_err_cycle", k, 16);
        check("t4_rd_off", mem_rd, 1'b0);
        check("t4_busy_off", busy, 1'b0);
        check("t4_valid_off", instr_valid, 1'b0);
        rdy_mode = 0;
        mem[16'h4000] = 8'hEF; mem[16'h4001] = 8'hBE;
        start = 1; pc_in = 16'h4000; tick(); start = 0;
        check("t4_err_cleared", err, 1'b0);
        tick(); tick();
        check("t4_refetch_instr", instr, 16'hBEEF);
        ack = 1; tick(); ack = 0;

        // 5: flush in RD_HI with mem_rdy, then flush+start in idle
        start = 1; pc_in = 16'h5000; tick(); start = 0;
        tick();
        flush = 1; tick(); flush = 0;
        check("t5_busy", busy, 1'b0);
        check("t5_valid", instr_valid, 1'b0);
        check("t5_rd", mem_rd, 1'b0);
        check("t5_instr_kept", instr, 16'hBEEF);
        check("t5_pc_next_kept", pc_next, 16'h5002);
        repeat (3) begin
            tick();
            check("t5_valid_stays_low", instr_valid, 1'b0);
        end
        flush = 1; start = 1; pc_in = 16'h5100; tick(); flush = 0; start = 0;
        check("t5_flush_beats_start", busy, 1'b0);

        // 6: asynchronous reset between edges in RD_LO
        rdy_mode = 2;
        start = 1; pc_in = 16'h6000; tick(); start = 0;
        check("t6_reading", mem_rd, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rd", mem_rd, 1'b0);
        check("t6_rst_addr", mem_addr, 16'h0000);
        check("t6_rst_instr", instr, 16'h0000);
        check("t6_rst_pc_next", pc_next, 16'h0000);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_err", err, 1'b0);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        tick();
        mem[16'h6000] = 8'h9A; mem[16'h6001] = 8'hBC;
        start = 1; pc_in = 16'h6000; tick(); start = 0;
        tick(); tick();
        check("t6_refetch_instr", instr, 16'hBC9A);
        ack = 1; tick(); ack = 0;

        // Randomized traffic across several memory responsiveness levels
        rdy_mode = 3;
        for (int s = 0; s < 6; s++) begin
            rdy_pct = pcts[s];
            for (int i = 0; i < 400; i++) begin
                tick();
                start = 1'($urandom_range(1));
                pc_in = 16'($urandom);
                flush = ($urandom_range(99) < 4);
                ack   = ($urandom_range(99) < 40);
            end
        end
        start = 0; flush = 0; ack = 0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
